// File: rtl/spi_master_cfg_if.sv
// Controller-side and SPI-side signal bundle for spi_master_cfg.
// The lsb_first member exists only when SPI_LSB_FIRST_EN is defined.
interface spi_master_cfg_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [CS_W-1:0]   cs_sel;
    logic [DATA_W-1:0] m_tx_data;
    logic              miso;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic [DATA_W-1:0] m_rx_data;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs;
    logic              busy;
    logic              done;

    // SPI master view: the design block itself
    modport master (
        input  start, cpol, cpha, cs_sel, m_tx_data, miso,
`ifdef SPI_LSB_FIRST_EN
        input  lsb_first,
`endif
        output m_rx_data, sclk, mosi, cs, busy, done
    );

    // Environment view: local controller plus attached slave
    modport slave (
        output start, cpol, cpha, cs_sel, m_tx_data, miso,
`ifdef SPI_LSB_FIRST_EN
        output lsb_first,
`endif
        input  m_rx_data, sclk, mosi, cs, busy, done
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master with runtime CPOL/CPHA and NUM_CS chip selects.
// Optional SPI_LSB_FIRST_EN adds a per-transfer lsb_first control.
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1
) (
    input  logic            clk,
    input  logic            reset,
    spi_master_cfg_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
    localparam logic [CS_W:0]     NUM_CS_L  = (CS_W + 1)'(NUM_CS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rx_out_q, rx_out_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;

    logic                lsb_in_s;
    logic                sel_ok_s;
    logic [DATA_W-1:0]   load_s;
    logic                edge_fire_s;
    logic [EDGE_W-1:0]   edge_num_s;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        for (int i = 0; i < NUM_CS; i++) begin
            r[i] = (sel != CS_W'(i));
        end
        return r;
    endfunction

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in_s = bus.lsb_first;
`else
    assign lsb_in_s = 1'b0;
`endif

    // LSB-first is handled by reversing the word once and always shifting from the top
    assign load_s   = lsb_in_s ? bit_rev(bus.m_tx_data) : bus.m_tx_data;
    assign sel_ok_s = ({1'b0, bus.cs_sel} < NUM_CS_L);

    // Next-state and output decode for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_out_d    = rx_out_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        edge_fire_s = 1'b0;
        edge_num_s  = edge_q;

        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                cs_d   = {NUM_CS{1'b1}};
                busy_d = 1'b0;
                cnt_d  = '0;
                edge_d = '0;
                if (bus.start && sel_ok_s) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    lsb_d   = lsb_in_s;
                    cs_d    = cs_decode(bus.cs_sel);
                    rx_d    = '0;
                    if (bus.cpha) begin
                        mosi_d = 1'b0;
                        tx_d   = load_s;
                    end else begin
                        mosi_d = load_s[DATA_W-1];
                        tx_d   = {load_s[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = XFER;
                    edge_fire_s = 1'b1;
                    edge_num_s  = EDGE_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                // The final half-period after the last edge lets the slave settle before HOLD
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        edge_fire_s = 1'b1;
                        edge_num_s  = edge_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cs_d     = {NUM_CS{1'b1}};
                    rx_out_d = rx_q;
                    sclk_d   = cpol_q;
                    mosi_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Odd edges are leading; sampling happens on leading edges only when cpha is 0
        if (edge_fire_s) begin
            edge_d = edge_num_s;
            sclk_d = ~sclk_q;
            if (edge_num_s[0] != cpha_q) begin
                rx_d = lsb_q ? {bus.miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso};
            end else if (edge_num_s != EDGE_LAST) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else begin
                mosi_d = mosi_q;
            end
        end else begin
            edge_d = edge_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rx_out_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= {NUM_CS{1'b1}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rx_out_q <= rx_out_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
        end
    end

    assign bus.m_rx_data = rx_out_q;
    assign bus.sclk      = sclk_q;
    assign bus.mosi      = mosi_q;
    assign bus.cs        = cs_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: behavioural SPI slave, expected-result queue, monitor.
module tb_spi_master_cfg;
    localparam int DW  = 8;
    localparam int CD  = 2;
    localparam int NC  = 3;
    localparam int CSW = 2;
    localparam int LAT = CD * (2 * DW + 2);
    localparam logic [NC-1:0] CS_IDLE = {NC{1'b1}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_cfg_if #(.DATA_W(DW), .NUM_CS(NC)) bus ();

    spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_slave;
        logic [NC-1:0] exp_cs;
        logic          pol;
        int            t_start;
    } exp_t;

    exp_t sb_q[$];
    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SPI slave ----------------
    logic [DW-1:0] slave_word;
    logic          slave_cpha;
    logic          slave_lsb;
    logic [DW-1:0] slave_last_rx;
    int            slave_last_edges;
    int            s_edges;

    function automatic int bitpos(input int i, input logic lsb);
        return lsb ? i : (DW - 1 - i);
    endfunction

    initial begin : slave_model
        logic [DW-1:0] s_tx, s_rx;
        logic s_cpha, s_lsb, prev_sclk;
        bit   cs_low, prev_cs_low;
        int   s_sent, s_got;
        bus.miso = 1'b0;
        prev_cs_low = 1'b0;
        prev_sclk = 1'b0;
        s_edges = 0; s_sent = 0; s_got = 0;
        s_tx = '0; s_rx = '0; s_cpha = 1'b0; s_lsb = 1'b0;
        slave_last_rx = '0;
        slave_last_edges = 0;
        forever begin
            @(posedge clk);
            #1;
            cs_low = (bus.cs != CS_IDLE);
            if (cs_low && !prev_cs_low) begin
                s_tx = slave_word; s_rx = '0; s_cpha = slave_cpha; s_lsb = slave_lsb;
                s_edges = 0; s_sent = 0; s_got = 0;
                if (!s_cpha) begin
                    bus.miso = s_tx[bitpos(0, s_lsb)];
                    s_sent = 1;
                end
            end else if (cs_low && (bus.sclk !== prev_sclk)) begin
                s_edges++;
                if (((s_edges % 2) == 1) == (s_cpha == 1'b0)) begin
                    if (s_got < DW) s_rx[bitpos(s_got, s_lsb)] = bus.mosi;
                    s_got++;
                end else if (s_sent < DW) begin
                    bus.miso = s_tx[bitpos(s_sent, s_lsb)];
                    s_sent++;
                end
            end else if (!cs_low && prev_cs_low) begin
                slave_last_rx = s_rx;
                slave_last_edges = s_edges;
            end
            prev_cs_low = cs_low;
            prev_sclk = bus.sclk;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [DW-1:0] prev_rx;
        logic prev_done;
        bit   skip;
        exp_t e;
        prev_rx = '0; prev_done = 1'b0; skip = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                skip = 1'b1;
            end else begin
                if (bus.busy) begin
                    if (sb_q.size() == 0) begin
                        asserts++; fails++;
                        $display("FAIL busy_without_request: actual=busy required=idle (t=%0t)", $time);
                    end else begin
                        check("cs_active", 32'(bus.cs), 32'(sb_q[0].exp_cs));
                    end
                end else begin
                    check("cs_idle", 32'(bus.cs), 32'(CS_IDLE));
                end
                if (bus.done) begin
                    check("done_width", 32'(prev_done), 32'd0);
                    if (sb_q.size() == 0) begin
                        asserts++; fails++;
                        $display("FAIL unexpected_done: actual=done required=no done (t=%0t)", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("m_rx_data", 32'(bus.m_rx_data), 32'(e.exp_rx));
                        check("slave_received", 32'(slave_last_rx), 32'(e.exp_slave));
                        check("sclk_edges", 32'(slave_last_edges), 32'(2 * DW));
                        check("done_latency", 32'(cyc - e.t_start), 32'(LAT));
                        check("sclk_idle_level", 32'(bus.sclk), 32'(e.pol));
                    end
                end else if (!skip) begin
                    check("rx_stable", 32'(bus.m_rx_data), 32'(prev_rx));
                end
                prev_rx = bus.m_rx_data;
                prev_done = bus.done;
                skip = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_lsb(input logic lsb);
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = lsb;
`endif
        slave_lsb = lsb;
    endtask

    task automatic scramble();
        bus.m_tx_data = DW'($urandom);
        bus.cpol      = 1'($urandom);
        bus.cpha      = 1'($urandom);
        bus.cs_sel    = CSW'($urandom);
    endtask

    task automatic push_exp(input logic [DW-1:0] tx, sw, input logic pol, input logic [CSW-1:0] sel);
        exp_t e;
        e.exp_rx = sw;
        e.exp_slave = tx;
        e.exp_cs = ~(NC'(1) << sel);
        e.pol = pol;
        e.t_start = cyc;
        sb_q.push_back(e);
    endtask

    // Called away from the edge; returns at the negedge after the start was sampled
    task automatic issue(input logic [DW-1:0] tx, sw, input logic pol, pha,
                         input logic [CSW-1:0] sel, input logic lsb);
        bus.m_tx_data = tx; bus.cpol = pol; bus.cpha = pha; bus.cs_sel = sel;
        set_lsb(lsb);
        slave_word = sw; slave_cpha = pha;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (32'(sel) < NC) push_exp(tx, sw, pol, sel);
        scramble();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            asserts++; fails++;
            $display("FAIL %s_timeout: actual=no done required=done", tag);
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit found;
        reset = 1'b1;
        bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.cs_sel = '0; bus.m_tx_data = '0;
        set_lsb(1'b0);
        slave_word = '0; slave_cpha = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sclk", 32'(bus.sclk), 32'd0);
        check("reset_mosi", 32'(bus.mosi), 32'd0);
        check("reset_cs", 32'(bus.cs), 32'(CS_IDLE));
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_rx", 32'(bus.m_rx_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0: A5 out, 3C back, first mosi bit is the MSB
        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 2'd0, 1'b0);
        check("mode0_first_mosi", 32'(bus.mosi), 32'd1);
        wait_done("mode0");
        repeat (2) @(negedge clk);

        // mode 3: idle level high before and after
        bus.cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("mode3_idle_before", 32'(bus.sclk), 32'd1);
        issue(8'hC3, 8'h5A, 1'b1, 1'b1, 2'd1, 1'b0);
        wait_done("mode3");
        bus.cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("mode3_idle_after", 32'(bus.sclk), 32'd1);

        // highest chip select, mode 1
        issue(8'hBE, 8'h12, 1'b0, 1'b1, 2'd2, 1'b0);
        wait_done("cs2");
        repeat (2) @(negedge clk);

        // start held through a transfer, then back-to-back start in the done cycle
        bus.m_tx_data = 8'h96; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_sel = 2'd1;
        slave_word = 8'h69; slave_cpha = 1'b0; set_lsb(1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(8'h96, 8'h69, 1'b0, 2'd1);
        scramble();
        wait_done("held_start");
        bus.m_tx_data = 8'h0F; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.cs_sel = 2'd2;
        slave_word = 8'hE1; slave_cpha = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_exp(8'h0F, 8'hE1, 1'b1, 2'd2);
        scramble();
        wait_done("back_to_back");
        repeat (2) @(negedge clk);

        // reset on SCLK edge 5: abort without done, then a clean transfer
        bus.cpol = 1'b0;
        issue(8'h5B, 8'hC7, 1'b0, 1'b0, 2'd0, 1'b0);
        bus.cpol = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            if (s_edges == 5) found = 1'b1;
        end
        if (!found) begin
            asserts++; fails++;
            $display("FAIL edge5_timeout: actual=no edge 5 required=edge 5");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("midreset_cs", 32'(bus.cs), 32'(CS_IDLE));
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_rx", 32'(bus.m_rx_data), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_sclk", 32'(bus.sclk), 32'd0);
        repeat (2) @(negedge clk);
        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 2'd0, 1'b0);
        wait_done("after_reset");
        repeat (2) @(negedge clk);

        // out-of-range chip select is ignored
        issue(8'h77, 8'h88, 1'b0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ignored_start_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end

`ifdef SPI_LSB_FIRST_EN
        issue(8'h01, 8'h80, 1'b0, 1'b0, 2'd0, 1'b1);
        check("lsb_first_mosi", 32'(bus.mosi), 32'd1);
        wait_done("lsb_first");
        repeat (2) @(negedge clk);
`endif

        // randomized transfers, gap of 0 means a start in the done cycle
        for (int n = 0; n < 24; n++) begin
            logic lsb_r;
`ifdef SPI_LSB_FIRST_EN
            lsb_r = 1'($urandom);
`else
            lsb_r = 1'b0;
`endif
            issue(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  CSW'($urandom_range(0, NC - 1)), lsb_r);
            wait_done("random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
